stream_packer_32to128: RTL and testbench

Upstream width adapter for the 128-bit SIMD stream processor. Collects four consecutive 32-bit Avalon-ST words into one 128-bit beat, with the first word in lane 0. Partial beats are emitted zero-padded on end-of-packet or on a software flush. Word and beat counters are readable over a small Avalon-MM CSR port. Byte order within each word passes through unchanged; endian swap is the downstream stage's job.

---
 rtl/stream_packer_32to128_if.sv | 33 +++
 rtl/stream_packer_32to128.sv | 157 +++++++++++++++
 tb/tb_stream_packer_32to128.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/stream_packer_32to128_if.sv
// CSR, input stream and output stream signals of the 32->128 packer.
// The slave modport is the packer's view; master is the surrounding system.
interface stream_packer_32to128_if;
  logic         avs_write;
  logic [31:0]  avs_writedata;
  logic         avs_read;
  logic [1:0]   avs_address;
  logic [31:0]  avs_readdata;
  logic         avs_readdatavalid;
  logic         asi_valid;
  logic [31:0]  asi_data;
  logic         asi_endofpacket;
  logic         asi_ready;
  logic         aso_valid;
  logic [127:0] aso_data;
  logic [1:0]   aso_empty;
  logic         aso_endofpacket;
  logic         aso_ready;

  modport slave (
    input  avs_write, avs_writedata, avs_read, avs_address,
    input  asi_valid, asi_data, asi_endofpacket, aso_ready,
    output avs_readdata, avs_readdatavalid, asi_ready,
    output aso_valid, aso_data, aso_empty, aso_endofpacket
  );

  modport master (
    output avs_write, avs_writedata, avs_read, avs_address,
    output asi_valid, asi_data, asi_endofpacket, aso_ready,
    input  avs_readdata, avs_readdatavalid, asi_ready,
    input  aso_valid, aso_data, aso_empty, aso_endofpacket
  );
endinterface

// File: rtl/stream_packer_32to128.sv
// Packs four 32-bit stream words into one 128-bit beat, lane 0 first.
// Define STREAM_PACKER_STATS_EN to build the word/beat counters.
module stream_packer_32to128 #(
  parameter logic [31:0] ID_MARKER = 32'h504B_0128
) (
  input logic                     clk,
  input logic                     reset,
  stream_packer_32to128_if.slave  bus
);

  logic [127:0] acc_q, acc_d;
  logic [1:0]   fill_q, fill_d;
  logic         flush_q, flush_d;
  logic         en_q, en_d;
  logic         ov_q, ov_d;
  logic [127:0] od_q, od_d;
  logic [1:0]   oe_q, oe_d;
  logic         oeop_q, oeop_d;
  logic [31:0]  rd_q, rd_d;
  logic         rdv_q, rdv_d;

  logic         slot_free;
  logic         ready;
  logic         accept;
  logic         ctrl_wr;
  logic [127:0] merged;
  logic [31:0]  wc_rd;
  logic [31:0]  bc_rd;
  logic         unused_wdata;

  assign slot_free = !ov_q || bus.aso_ready;
  assign ready     = !reset && en_q && !flush_q && slot_free;
  assign accept    = bus.asi_valid && ready;
  assign ctrl_wr   = bus.avs_write && bus.avs_address == 2'd0;
  assign unused_wdata = ^bus.avs_writedata[31:2];

  always_comb begin
    merged = acc_q;
    merged[{fill_q, 5'b0} +: 32] = bus.asi_data;
  end

  always_comb begin
    acc_d   = acc_q;
    fill_d  = fill_q;
    flush_d = flush_q;
    en_d    = en_q;
    ov_d    = ov_q;
    od_d    = od_q;
    oe_d    = oe_q;
    oeop_d  = oeop_q;
    if (bus.aso_ready) ov_d = 1'b0;
    if (accept) begin
      if (fill_q == 2'd3 || bus.asi_endofpacket) begin
        ov_d   = 1'b1;
        od_d   = merged;
        oe_d   = 2'd3 - fill_q;
        oeop_d = bus.asi_endofpacket;
        acc_d  = '0;
        fill_d = 2'd0;
      end else begin
        acc_d  = merged;
        fill_d = fill_q + 2'd1;
      end
    end else if (flush_q && slot_free) begin
      flush_d = 1'b0;
      // 4 - fill in two bits: 1->3, 2->2, 3->1
      if (fill_q != 2'd0) begin
        ov_d   = 1'b1;
        od_d   = acc_q;
        oe_d   = 2'd0 - fill_q;
        oeop_d = 1'b0;
        acc_d  = '0;
        fill_d = 2'd0;
      end
    end
    if (ctrl_wr) begin
      en_d = bus.avs_writedata[0];
      if (bus.avs_writedata[1]) flush_d = 1'b1;
    end
  end

`ifdef STREAM_PACKER_STATS_EN
  logic [31:0] wc_q, wc_d;
  logic [31:0] bc_q, bc_d;

  always_comb begin
    wc_d = wc_q + {31'b0, accept};
    bc_d = bc_q + {31'b0, ov_q && bus.aso_ready};
    if (bus.avs_write && bus.avs_address == 2'd1) wc_d = '0;
    if (bus.avs_write && bus.avs_address == 2'd2) bc_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wc_q <= '0;
      bc_q <= '0;
    end else begin
      wc_q <= wc_d;
      bc_q <= bc_d;
    end
  end

  assign wc_rd = wc_q;
  assign bc_rd = bc_q;
`else
  assign wc_rd = '0;
  assign bc_rd = '0;
`endif

  always_comb begin
    rdv_d = bus.avs_read;
    rd_d  = rd_q;
    if (bus.avs_read) begin
      unique case (bus.avs_address)
        2'd0:    rd_d = {31'b0, en_q};
        2'd1:    rd_d = wc_rd;
        2'd2:    rd_d = bc_rd;
        default: rd_d = ID_MARKER;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q   <= '0;
      fill_q  <= '0;
      flush_q <= 1'b0;
      en_q    <= 1'b1;
      ov_q    <= 1'b0;
      od_q    <= '0;
      oe_q    <= '0;
      oeop_q  <= 1'b0;
      rd_q    <= '0;
      rdv_q   <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      fill_q  <= fill_d;
      flush_q <= flush_d;
      en_q    <= en_d;
      ov_q    <= ov_d;
      od_q    <= od_d;
      oe_q    <= oe_d;
      oeop_q  <= oeop_d;
      rd_q    <= rd_d;
      rdv_q   <= rdv_d;
    end
  end

  assign bus.asi_ready         = ready;
  assign bus.aso_valid         = ov_q;
  assign bus.aso_data          = od_q;
  assign bus.aso_empty         = oe_q;
  assign bus.aso_endofpacket   = oeop_q;
  assign bus.avs_readdata      = rd_q;
  assign bus.avs_readdatavalid = rdv_q;

endmodule

// File: tb/tb_stream_packer_32to128.sv
// Directed bench for stream_packer_32to128: packing, eop, stall,
// flush, CSR and mid-packet reset, with hand-computed expectations.
module tb_stream_packer_32to128;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  stream_packer_32to128_if bus ();

  stream_packer_32to128 dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

`ifdef STREAM_PACKER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic [127:0] mq_data[$];
  logic [1:0]   mq_empty[$];
  logic         mq_eop[$];

  always @(posedge clk) begin
    if (!reset && bus.aso_valid && bus.aso_ready) begin
      mq_data.push_back(bus.aso_data);
      mq_empty.push_back(bus.aso_empty);
      mq_eop.push_back(bus.aso_endofpacket);
    end
  end

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [31:0] d, input logic e,
                      output int waits);
    waits = 0;
    bus.asi_valid = 1'b1;
    bus.asi_data = d;
    bus.asi_endofpacket = e;
    #1;
    while (!bus.asi_ready && waits < 50) begin
      @(negedge clk);
      #1;
      waits++;
    end
    if (waits >= 50) chk("send_ready_timeout", bus.asi_ready, 1);
    @(negedge clk);
    bus.asi_valid = 1'b0;
    bus.asi_endofpacket = 1'b0;
  endtask

  task automatic csr_wr(input logic [1:0] a, input logic [31:0] d);
    bus.avs_write = 1'b1;
    bus.avs_address = a;
    bus.avs_writedata = d;
    @(negedge clk);
    bus.avs_write = 1'b0;
  endtask

  task automatic csr_rd(input logic [1:0] a, output logic [31:0] d);
    bus.avs_read = 1'b1;
    bus.avs_address = a;
    @(negedge clk);
    bus.avs_read = 1'b0;
    chk("rd_valid", bus.avs_readdatavalid, 1);
    d = bus.avs_readdata;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int w;
    int wsum;
    logic [31:0] rd;
    logic [31:0] wd [8];

    bus.avs_write = 1'b0;
    bus.avs_writedata = '0;
    bus.avs_read = 1'b0;
    bus.avs_address = '0;
    bus.asi_valid = 1'b0;
    bus.asi_data = '0;
    bus.asi_endofpacket = 1'b0;
    bus.aso_ready = 1'b1;

    // reset state
    idle(2);
    chk("rst_asi_ready", bus.asi_ready, 0);
    chk("rst_aso_valid", bus.aso_valid, 0);
    chk("rst_aso_data", bus.aso_data, 0);
    chk("rst_aso_empty", bus.aso_empty, 0);
    chk("rst_aso_eop", bus.aso_endofpacket, 0);
    chk("rst_readdata", bus.avs_readdata, 0);
    chk("rst_rdvalid", bus.avs_readdatavalid, 0);
    reset = 1'b0;
    #1;
    chk("post_rst_ready", bus.asi_ready, 1);
    idle(1);

    // full beat
    wsum = 0;
    send(32'h11111111, 1'b0, w); wsum += w;
    send(32'h22222222, 1'b0, w); wsum += w;
    send(32'h33333333, 1'b0, w); wsum += w;
    send(32'h44444444, 1'b0, w); wsum += w;
    chk("t1_ready_held", wsum, 0);
    chk("t1_valid", bus.aso_valid, 1);
    chk("t1_data", bus.aso_data,
        128'h44444444_33333333_22222222_11111111);
    chk("t1_empty", bus.aso_empty, 0);
    chk("t1_eop", bus.aso_endofpacket, 0);
    idle(1);
    chk("t1_drained", bus.aso_valid, 0);

    // eop on third word
    send(32'hAAAA0001, 1'b0, w);
    send(32'hBBBB0002, 1'b0, w);
    send(32'hCCCC0003, 1'b1, w);
    chk("t2_data", bus.aso_data,
        128'h00000000_CCCC0003_BBBB0002_AAAA0001);
    chk("t2_empty", bus.aso_empty, 1);
    chk("t2_eop", bus.aso_endofpacket, 1);

    // eop on fourth word is a full beat
    send(32'h01, 1'b0, w);
    send(32'h02, 1'b0, w);
    send(32'h03, 1'b0, w);
    send(32'h04, 1'b1, w);
    chk("t2b_data", bus.aso_data,
        128'h00000004_00000003_00000002_00000001);
    chk("t2b_empty", bus.aso_empty, 0);
    chk("t2b_eop", bus.aso_endofpacket, 1);
    idle(2);

    // backpressure
    mq_data.delete(); mq_empty.delete(); mq_eop.delete();
    for (int i = 0; i < 8; i++) wd[i] = 32'hD000_0000 + i;
    for (int i = 0; i < 5; i++) send(wd[i], 1'b0, w);
    bus.aso_ready = 1'b0;
    for (int i = 5; i < 8; i++) send(wd[i], 1'b0, w);
    chk("t3_ready_drop", bus.asi_ready, 0);
    chk("t3_valid", bus.aso_valid, 1);
    idle(3);
    chk("t3_stable", bus.aso_data, {wd[7], wd[6], wd[5], wd[4]});
    chk("t3_still_valid", bus.aso_valid, 1);
    chk("t3_still_blocked", bus.asi_ready, 0);
    bus.aso_ready = 1'b1;
    idle(2);
    chk("t3_beats", mq_data.size(), 2);
    if (mq_data.size() == 2) begin
      chk("t3_beat1", mq_data[0], {wd[3], wd[2], wd[1], wd[0]});
      chk("t3_beat2", mq_data[1], {wd[7], wd[6], wd[5], wd[4]});
      chk("t3_empty2", mq_empty[1], 0);
    end

    // software flush
    send(32'h0000_00A1, 1'b0, w);
    send(32'h0000_00B2, 1'b0, w);
    csr_wr(2'd0, 32'h3);
    #1;
    chk("t4_blocked", bus.asi_ready, 0);
    idle(1);
    chk("t4_valid", bus.aso_valid, 1);
    chk("t4_data", bus.aso_data,
        128'h00000000_00000000_000000B2_000000A1);
    chk("t4_empty", bus.aso_empty, 2);
    chk("t4_eop", bus.aso_endofpacket, 0);
    csr_rd(2'd0, rd);
    chk("t4_ctrl", rd, 32'h1);
    chk("t4_ready_back", bus.asi_ready, 1);

    // flush with nothing held emits no beat
    idle(2);
    csr_wr(2'd0, 32'h3);
    idle(2);
    chk("t4b_no_beat", bus.aso_valid, 0);
    chk("t4b_ready", bus.asi_ready, 1);

    // counters and ID
    csr_wr(2'd1, 32'h0);
    csr_wr(2'd2, 32'h0);
    for (int i = 0; i < 12; i++) send(32'hE000_0000 + i, 1'b0, w);
    idle(3);
    csr_rd(2'd1, rd);
    chk("t5_wcount", rd, STATS ? 32'd12 : 32'd0);
    csr_rd(2'd2, rd);
    chk("t5_bcount", rd, STATS ? 32'd3 : 32'd0);
    csr_rd(2'd3, rd);
    chk("t5_id", rd, 32'h504B0128);
    csr_wr(2'd3, 32'hDEADBEEF);
    csr_rd(2'd3, rd);
    chk("t5_id_ro", rd, 32'h504B0128);
    csr_wr(2'd1, 32'h0);
    csr_rd(2'd1, rd);
    chk("t5_wclr", rd, 32'd0);
    csr_rd(2'd2, rd);
    chk("t5_bkeep", rd, STATS ? 32'd3 : 32'd0);

    // disable blocks input
    csr_wr(2'd0, 32'h0);
    #1;
    chk("t5_dis_ready", bus.asi_ready, 0);
    csr_rd(2'd0, rd);
    chk("t5_dis_ctrl", rd, 32'h0);
    csr_wr(2'd0, 32'h1);
    #1;
    chk("t5_en_ready", bus.asi_ready, 1);
    idle(1);

    // reset mid-packet
    send(32'h5555_0001, 1'b0, w);
    send(32'h5555_0002, 1'b0, w);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    idle(1);
    chk("t6_no_beat", bus.aso_valid, 0);
    send(32'h6666_0001, 1'b0, w);
    send(32'h6666_0002, 1'b0, w);
    send(32'h6666_0003, 1'b0, w);
    chk("t6_not_yet", bus.aso_valid, 0);
    send(32'h6666_0004, 1'b0, w);
    chk("t6_valid", bus.aso_valid, 1);
    chk("t6_data", bus.aso_data,
        128'h66660004_66660003_66660002_66660001);
    chk("t6_empty", bus.aso_empty, 0);
    idle(2);
    csr_rd(2'd1, rd);
    chk("t6_wcount", rd, STATS ? 32'd4 : 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
